ifetch_queue: RTL
=================

# ifetch_queue

Instruction fetch unit with a small prefetch buffer, sitting directly upstream of the IF/ID pipeline register of the five-stage RISC-V core. Owns the fetch PC, issues word reads to the instruction memory (one-cycle read latency), and buffers returned instructions with their PCs in a FIFO. Decode consumes them through a valid/ready handshake. Taken branch, JAL and JALR resolution redirect the unit, which discards all buffered and in-flight instructions.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  32  byte address of request; bits [1:0] always 0.
- imem_rdata  in  32  read data, valid the cycle after an accepted request.
- redirect_valid  in  1  flush and restart fetch from redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- hold  in  1  debug freeze of the whole unit.
- if_valid  out  1  head instruction available to decode.
- if_pc  out  32  PC of head instruction.
- if_instr  out  32  head instruction; 32'h0000_0013 (NOP) when if_valid=0.
- if_ready  in  1  decode accepts head this cycle (low on load-use stall).
- fetch_pc  out  32  next address to be requested (debug).

## Operation
- State: fetch_pc, FIFO of {pc, instr}, count, inflight flag with inflight_pc, drop flag.
- Request: imem_req = !rst && !hold && !redirect_valid && (count + inflight - pop) < DEPTH; imem_addr = fetch_pc. On request: fetch_pc += 4 (wraps modulo 2^32), inflight <= 1, inflight_pc <= fetch_pc, drop <= 0.
- Response: cycle after request, if inflight && !drop, push {inflight_pc, imem_rdata}; inflight clears unless a new request issues.
- Pop: when if_valid && if_ready && !hold; head advances.
- Credit rule guarantees no push into a full queue; overflow is a design error (assertion).
- Redirect (priority over hold, pop and push): count <= 0, fetch_pc <= {redirect_pc[31:2],2'b00}, drop <= inflight (response of the in-flight request is discarded), no request that cycle.
- Hold without redirect: no request, no pop; a response already in flight is still captured (push only).
- Push and pop same cycle: count unchanged.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, if_valid 0, if_pc 0, if_instr 32'h0000_0013, fetch_pc RESET_PC; queue empty, inflight 0, drop 0.
- First request in the first cycle after rst deasserts.
- Redirect asserted in cycle N: request for redirect_pc in N+1, data N+2, if_valid N+2 (bypass) or N+3 (no bypass).
- Steady state with if_ready=1: one instruction per cycle, no bubbles.
- Reset asserted mid-operation: state cleared asynchronously; in-flight response discarded.

## Configuration
- IFQ_BYPASS_EN defined: when queue empty and a non-dropped response arrives, if_valid/if_pc/if_instr driven combinationally from inflight_pc/imem_rdata; if popped that cycle it is not written to the FIFO.
- Undefined: every response is written first; outputs come only from the FIFO head (fully registered outputs, one extra cycle latency).

## Structure
- Package ifq_pkg: NOP_INSTR constant 32'h0000_0013, ifq_entry_t {pc[31:0], instr[31:0]}, clog2-based pointer width helper.
- Sub-module ifq_fifo: synchronous FIFO of ifq_entry_t with push, pop, flush, count, head; fetch-PC and credit logic stay in ifetch_queue.

## Test plan
- Reset release, if_ready=1, memory word i = 32'h1000_0000+i: imem_addr 0,4,8,...; if_pc/if_instr 0/32'h1000_0000, 4/32'h1000_0001, ... one per cycle, no gaps.
- if_ready=0 for 10 cycles: exactly DEPTH=4 entries buffered, imem_req low once full; release -> PCs continue with no skip or duplicate.
- Redirect to 32'h0000_0103 while queue holds 3 entries and a request is in flight: queue empties, in-flight data never appears, next if_pc 32'h0000_0100.
- Redirect coinciding with pop and with hold=1: redirect wins; next valid if_pc is redirect target.
- hold=1 for 5 cycles mid-stream: no requests, no pops, fetch_pc stable; resume in order.
- fetch_pc 32'hFFFF_FFFC: next request address 32'h0000_0000; bypass build shows if_valid one cycle earlier after redirect than non-bypass build.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; head is read combinationally.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  ifq_entry_t                    push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [ptr_width(DEPTH):0]     count,
    output ifq_entry_t                    head
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count == FULL_CNT));

endmodule

// File: rtl/ifetch_queue.sv
// Fetch unit: owns fetch PC, issues imem reads under a credit limit, buffers responses.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic [31:0] fetch_pc
);

    localparam int unsigned CNT_W = ptr_width(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic             drop;
    logic [CNT_W-1:0] fifo_count;
    ifq_entry_t       fifo_head;
    ifq_entry_t       rsp_entry;
    ifq_entry_t       head_sel;
    logic             fifo_empty;
    logic             rsp_valid;
    logic             bypass;
    logic             pop;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CNT_W:0]   occupancy;

    assign fifo_empty = (fifo_count == '0);
    assign rsp_valid  = inflight && !drop;
    assign rsp_entry  = '{pc: inflight_pc, instr: imem_rdata};

`ifdef IFQ_BYPASS_EN
    assign bypass = fifo_empty && rsp_valid;
`else
    assign bypass = 1'b0;
`endif

    assign if_valid = !fifo_empty || bypass;
    assign pop      = if_valid && if_ready && !hold && !redirect_valid;
    assign fifo_pop = pop && !fifo_empty;
    // A bypassed response consumed this cycle never enters the FIFO.
    assign fifo_push = rsp_valid && !redirect_valid && !(bypass && pop);

    always_comb begin
        head_sel = fifo_head;
        if (fifo_empty) head_sel = rsp_entry;
    end

    assign if_pc    = if_valid ? head_sel.pc    : '0;
    assign if_instr = if_valid ? head_sel.instr : NOP_INSTR;

    // Entries that will occupy the queue once the pending response lands.
    assign occupancy = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

    assign imem_req  = !rst && !hold && !redirect_valid && (occupancy < DEPTH_L);
    assign imem_addr = fetch_pc_q;
    assign fetch_pc  = fetch_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            drop       <= inflight;
            inflight   <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc_q  <= fetch_pc_q + 32'd4;
                inflight_pc <= fetch_pc_q;
                drop        <= 1'b0;
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule
